// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Runtime-programmable serial bit-pattern detector.
//                It has a pattern of 1..MAX_LEN bits and selectable
//                overlapping or non-overlapping matching.
//                It drives a same-cycle Mealy match pulse on `out`.
//                Optional macro SEQDET_COUNT_EN builds a saturating match
//                counter with a clear input. When the macro is undefined,
//                match_count is tied to zero and cnt_clr is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN) + 1,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b1101,
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_def_len = LEN_W'(DEF_LEN);

    // Latched configuration
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic               r_err;

    // Bit history (newest at bit 0) and count of accepted bits
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;

    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_fill_ok;
    logic               w_pat_ok;
    logic               w_match;
    logic               w_len_bad;

    // Candidate window: the last MAX_LEN-1 accepted bits plus the live bit
    assign w_window = {r_hist[MAX_LEN-2:0], in_bit};

    // Only the low `len` bits of the window and pattern take part in the compare
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    // fill >= len-1, written as fill+1 >= len so a zero length cannot underflow
    assign w_fill_ok = ({1'b0, r_fill} + (LEN_W+1)'(1)) >= {1'b0, r_len};
    assign w_pat_ok  = ((w_window ^ r_pat) & w_mask) == '0;
    assign w_match   = in_valid & ~cfg_load & ~r_err & ~rst & w_fill_ok & w_pat_ok;
    assign out       = w_match;
    assign cfg_err   = r_err;

    assign w_len_bad = (cfg_len == '0) || (int'(cfg_len) > MAX_LEN);

    // Configuration registers and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat <= DEF_PATTERN;
            r_len <= c_def_len;
            r_ovl <= DEF_OVERLAP;
            r_err <= 1'b0;
        end else if (cfg_load) begin
            r_pat <= cfg_pattern;
            r_len <= cfg_len;
            r_ovl <= cfg_overlap;
            r_err <= w_len_bad;
        end
    end

    // Shift history; a non-overlapping match restarts from an empty history
    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (in_valid && !r_err) begin
            if (w_match && !r_ovl) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= {r_hist[MAX_LEN-2:0], in_bit};
                if (r_fill != c_max_len) begin
                    r_fill <= r_fill + LEN_W'(1);
                end
            end
        end
    end

`ifdef SEQDET_COUNT_EN
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0] r_cnt;

    // Saturating match counter; any clear source beats a coincident match
    always_ff @(posedge clk) begin
        if (rst || cfg_load || cnt_clr) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match_count = r_cnt;

    // The oldest history bit only ever leaves the window
    logic w_unused_bits;
    assign w_unused_bits = r_hist[MAX_LEN-1];
`else
    assign match_count = '0;

    // Without the counter the clear input has no function
    logic w_unused_bits;
    assign w_unused_bits = cnt_clr ^ r_hist[MAX_LEN-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector_param
//  Description : Scoreboard bench for seq_detector_param. Directed vectors
//                push expected out/match_count/cfg_err values into a queue.
//                A negedge monitor pops the queue and compares the values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;
    localparam int CNT_W   = 2;
`ifdef SEQDET_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_bit = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               out;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    seq_detector_param #(
        .MAX_LEN(MAX_LEN),
        .LEN_W(LEN_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_bit(in_bit),
        .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr),
        .out(out),
        .match_count(match_count),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // kind: 0 = out, 1 = match_count, 2 = cfg_err
    typedef struct {
        int    kind;
        int    exp;
        string name;
    } item_t;

    item_t sb[$];
    int checks   = 0;
    int failures = 0;

    // Monitor: compare every queued expectation against the DUT mid-cycle
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            item_t it;
            int    act;
            it = sb.pop_front();
            case (it.kind)
                0:       act = int'(out);
                1:       act = int'(match_count);
                default: act = int'(cfg_err);
            endcase
            checks++;
            if (act != it.exp) begin
                failures++;
                $display("FAIL %s: got %0d expected %0d at %0t", it.name, act, it.exp, $time);
            end
        end
    end

    function automatic int ecnt(input int n);
        return CNT_ON ? n : 0;
    endfunction

    task automatic push(input int kind, input int exp, input string name);
        item_t it;
        it.kind = kind;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    // Drive one cycle of stream input and queue the expected out value
    task automatic step(input logic v, input logic b, input int exp_out, input string name);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
        in_valid = v;
        in_bit   = b;
        push(0, exp_out, name);
    endtask

    // One cfg_load cycle, with a live bit that must be ignored
    task automatic load(input logic [MAX_LEN-1:0] p, input int len, input logic ovl);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        cnt_clr     = 1'b0;
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        in_valid    = 1'b1;
        in_bit      = 1'b1;
        push(0, 0, "out_during_load");
    endtask

    // Stream bits MSB-first from a vector with a per-bit expected out mask
    task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n, input string name);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], int'(exp[i]), name);
        end
    endtask

    initial begin
        // Reset, with a live stream that must produce nothing
        @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        push(0, 0, "out_in_reset");
        @(posedge clk);
        #1;
        push(0, 0, "out_in_reset2");
        step(1'b0, 1'b0, 0, "idle_after_reset");
        push(1, 0, "cnt_after_reset");
        push(2, 0, "err_after_reset");

        // Default 1101 non-overlap: 1,1,0,1,1,0,1 -> pulse on bit 4 only
        stream(16'b1101101, 16'b0001000, 7, "default_nonovl");
        step(1'b0, 1'b0, 0, "idle");
        push(1, ecnt(1), "cnt_default");

        // Overlap mode on the same stream -> bits 4 and 7
        load(8'b1101, 4, 1'b1);
        step(1'b0, 1'b0, 0, "idle");
        push(1, 0, "cnt_cleared_by_load");
        stream(16'b1101101, 16'b0001001, 7, "overlap");
        step(1'b0, 1'b0, 0, "idle");
        push(1, ecnt(2), "cnt_overlap");

        // Valid gaps between bits of 1,1,0,1
        load(8'b1101, 4, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] v;
            v = 4'b1101;
            step(1'b1, v[i], (i == 0) ? 1 : 0, "gap_bit");
            if (i != 0) begin
                for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 0, "gap_idle");
            end
        end
        step(1'b0, 1'b0, 0, "idle");
        push(1, ecnt(1), "cnt_gaps");

        // len=1, pattern bit 0 = 1, upper pattern bits are don't-care
        load(8'hA5, 1, 1'b0);
        stream(16'b101, 16'b101, 3, "len1");

        // len=MAX_LEN overlap, pattern streamed twice -> one pulse per copy
        load(8'b10110011, 8, 1'b1);
        stream(16'b1011001110110011, 16'b0000000100000001, 16, "len8");
        step(1'b0, 1'b0, 0, "idle");
        push(1, ecnt(2), "cnt_len8");

        // Illegal length 0 and MAX_LEN+1
        load(8'b1101, 0, 1'b1);
        step(1'b0, 1'b0, 0, "idle");
        push(2, 1, "err_len0");
        stream(16'b11011101, 16'b0, 8, "illegal_len0");
        load(8'b1101, 9, 1'b1);
        step(1'b0, 1'b0, 0, "idle");
        push(2, 1, "err_len9");
        stream(16'b1101, 16'b0, 4, "illegal_len9");

        // Legal reload recovers
        load(8'b1101, 4, 1'b0);
        step(1'b0, 1'b0, 0, "idle");
        push(2, 0, "err_recovered");
        stream(16'b1101, 16'b0001, 4, "recovered");

        // Reset mid-sequence discards the partial match
        stream(16'b110, 16'b0, 3, "pre_reset");
        @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b0;
        push(0, 0, "out_in_reset3");
        step(1'b1, 1'b1, 0, "after_reset_bit");
        stream(16'b1101, 16'b0001, 4, "default_after_reset");

        // Counter saturation: len=1 overlap, five matches
        load(8'b1, 1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1, 1, "sat_match");
            step(1'b0, 1'b0, 0, "idle");
            push(1, ecnt((i > 3) ? 3 : i), "cnt_sat");
        end

        // Clear coincident with a match
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_bit = 1'b1; cnt_clr = 1'b1;
        push(0, 1, "match_with_clr");
        step(1'b0, 1'b0, 0, "idle");
        push(1, 0, "cnt_clr_wins");

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector for the sequential-circuits library. It generalises the fixed 1101 non-overlapping Mealy detector with a runtime-programmable pattern and length (1..MAX_LEN), selectable overlapping or non-overlapping matching, input-valid gating and an optional saturating match counter. It sits on a 1-bit serial stream and raises a same-cycle Mealy `out` pulse on the bit that completes the pattern.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits, must be at least 2.
- `LEN_W`, $clog2(MAX_LEN)+1: width of `cfg_len`.
- `CNT_W`, 8: width of `match_count`.
- `DEF_PATTERN`, 'b1101: pattern loaded at reset, right-aligned.
- `DEF_LEN`, 4: length loaded at reset.
- `DEF_OVERLAP`, 0: overlap mode loaded at reset.

- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `in_bit` is a stream bit this cycle.
- `in_bit`  in  1  serial data bit.
- `cfg_load`  in  1  latch `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- `cfg_pattern`  in  MAX_LEN  pattern, right-aligned; bit `cfg_len-1` is the first bit received.
- `cfg_len`  in  LEN_W  pattern length.
- `cfg_overlap`  in  1  1 = overlapping, 0 = non-overlapping.
- `cnt_clr`  in  1  clear `match_count`.
- `out`  out  1  Mealy match pulse, combinational.
- `match_count`  out  CNT_W  saturating number of matches.
- `cfg_err`  out  1  the latched length is illegal.

## Operation
- **State**
  - `hist[MAX_LEN-1:0]` holds previously accepted bits, newest at bit 0.
  - `fill` is the count of accepted bits, saturating at MAX_LEN.
  - The latched config registers are `pat`, `len` and `ovl`.
- **Match condition**
  - `out` = `in_valid` & !`cfg_load` & !`cfg_err` & (`fill` >= `len`-1) & ({`hist`[`len`-2:0], `in_bit`} == `pat`[`len`-1:0]).
  - For `len`=1 the condition reduces to `in_bit` == `pat`[0].
  - Bits of `pat` above `len`-1 are ignored.
- **Accepted bit, no match:** `hist` <= {`hist`[MAX_LEN-2:0], `in_bit`}; `fill` increments, saturating.
- **Accepted bit with match**
  - If `ovl`=1, the bit shifts in exactly as in the no-match case.
  - If `ovl`=0, `hist` <= 0 and `fill` <= 0. The next match therefore needs `len` fresh bits.
- **`in_valid`=0:** `hist`, `fill` and the counter hold; `out`=0.
- **`cfg_load`=1**
  - Config registers are latched and `hist`/`fill` are cleared.
  - `match_count` is cleared.
  - `in_bit` is ignored that cycle and `out`=0.
  - `cfg_err` <= (`cfg_len`==0) | (`cfg_len`>MAX_LEN).
- **`cfg_err`=1:** `out` is forced to 0 and `hist`/`fill` stay cleared until a legal `cfg_load`.
- **Reset (`rst`=1)**
  - Config becomes `DEF_PATTERN`/`DEF_LEN`/`DEF_OVERLAP`.
  - `hist`=0, `fill`=0, `match_count`=0, `cfg_err`=0.
  - `out`=0 during the reset cycle.
  - `rst` has priority over `cfg_load`, `cnt_clr` and `in_valid`.
  - Asserting `rst` mid-sequence discards the partial match.

## Timing
- `out` is valid in the same cycle as the completing `in_bit`, with zero latency. It is combinational from `in_valid`/`in_bit`/`cfg_load` and registered state.
- Downstream logic samples `out` on the same rising edge.
- `hist`, `fill`, `match_count` and `cfg_err` update on the rising edge.
- `match_count` reflects a match one cycle after its `out` pulse.
- A new configuration applies to the first `in_valid` bit in the cycle after `cfg_load`.
- `cnt_clr` together with a match in the same cycle: the clear wins and `match_count` becomes 0.
- `cfg_load` together with `cnt_clr`: the counter becomes 0.
- `match_count` saturates at 2^CNT_W-1 and never wraps.

## Configuration
- The macro is `SEQDET_COUNT_EN`.
- When defined, the `match_count` counter and the `cnt_clr` logic are built as described above.
- When undefined, `match_count` is tied to 0 and `cnt_clr` is ignored; no counter flops are inferred.
- `out` and `cfg_err` behave identically in both builds.

## Test plan
- **Default config after reset, non-overlap:** drive `in_valid`=1 with bits 1,1,0,1,1,0,1 → `out`=1 on bit 4 only (1-based). `match_count`=1.
- **Overlap mode:** load pattern 'b1101, `len`=4, `cfg_overlap`=1, then the same stream → `out`=1 on bits 4 and 7. `match_count`=2.
- **Valid gaps:** the stream 1,1,0,1 with `in_valid`=0 for 3 cycles between each bit → exactly one `out` pulse, on the final valid bit, and `out`=0 during the gaps.
- **Edge lengths:**
  - `len`=1 with pattern 'b1 and stream 1,0,1 → `out`=1 on bits 1 and 3.
  - `len`=MAX_LEN with pattern 'b10110011 in overlap mode, streamed twice back-to-back → one pulse per copy.
- **Illegal and recovery:**
  - `cfg_len`=0 → `cfg_err`=1 and `out` stays 0 on any stream.
  - Reload with `len`=4 → `cfg_err`=0 and detection resumes.
  - `rst` after bits 1,1,0 then a final 1 → no pulse.
- **Counter (with SEQDET_COUNT_EN, CNT_W=2):**
  - Five overlap-mode matches → count reads 1,2,3,3,3.
  - `cnt_clr` coincident with a match → count reads 0.
